// File: rtl/calc_top.sv
// Eight-digit BCD keypad calculator: edge-detected commands, shift-add multiply,
// double-dabble result conversion and seven-segment decode of registered state.
module calc_top (
  input  logic       clock,
  input  logic       reset,     // active low, asynchronous
  input  logic [3:0] cmd,
  output logic [6:0] displays [7:0],
  output logic [1:0] status
);

  localparam logic [2:0] S_EDIT = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  localparam logic [53:0] MAX_RES = 54'd99_999_999;

  function automatic logic [26:0] bcd2bin(input logic [31:0] b);
    logic [26:0] acc;
    acc = '0;
    for (int i = 7; i >= 0; i--) acc = acc * 27'd10 + {23'd0, b[i*4 +: 4]};
    return acc;
  endfunction

  function automatic logic [3:0] sig_cnt(input logic [31:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) if (b[i*4 +: 4] != 4'd0) n = 4'(i + 1);
    return n;
  endfunction

  // One double-dabble iteration: +3 on every digit >= 5, then shift {bcd,bin} left.
  function automatic logic [58:0] dd_step(input logic [31:0] bcd, input logic [26:0] bin);
    logic [31:0] adj;
    adj = bcd;
    for (int i = 0; i < 8; i++)
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    return {adj, bin} << 1;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic [3:0]  prev_cmd_q, prev_cmd_d;
  logic [31:0] entry_q, entry_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [26:0] a_q, a_d;
  logic [1:0]  op_q, op_d;
  logic        op_wait_q, op_wait_d;
  logic        res_flag_q, res_flag_d;
  logic [53:0] res_q, res_d;
  logic [53:0] mcand_q, mcand_d;
  logic [26:0] mplier_q, mplier_d;
  logic [26:0] bin_q, bin_d;
  logic [31:0] bcd_q, bcd_d;
  logic [4:0]  iter_q, iter_d;

  logic        accept, is_digit, is_op, do_clear;
  logic [26:0] entry_bin;
  logic [58:0] step;

  always_comb begin
    state_d    = state_q;
    prev_cmd_d = cmd;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    op_d       = op_q;
    op_wait_d  = op_wait_q;
    res_flag_d = res_flag_q;
    res_d      = res_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    do_clear   = 1'b0;

    accept    = (cmd != prev_cmd_q) && (cmd != 4'd15);
    is_digit  = (cmd <= 4'd9);
    is_op     = (cmd >= 4'd10) && (cmd <= 4'd12);
    entry_bin = bcd2bin(entry_q);
    step      = dd_step(bcd_q, bin_q);

    case (state_q)
      S_EDIT: begin
        if (accept) begin
          if (is_digit) begin
            if (res_flag_q) begin
              entry_d    = {28'd0, cmd};
              cnt_d      = (cmd != 4'd0) ? 4'd1 : 4'd0;
              res_flag_d = 1'b0;
            end else if (cnt_q < 4'd8) begin
              entry_d = {entry_q[27:0], cmd};
              if (cnt_q != 4'd0 || cmd != 4'd0) cnt_d = cnt_q + 4'd1;
            end
            op_wait_d = 1'b0;
          end else if (is_op) begin
            // Back-to-back operators only swap the pending operator.
            if (!op_wait_q) begin
              a_d     = entry_bin;
              entry_d = '0;
              cnt_d   = '0;
            end
            op_d       = cmd[1:0] - 2'd1;
            op_wait_d  = 1'b1;
            res_flag_d = 1'b0;
          end else if (cmd == 4'd13 && op_q != OP_NONE) begin
            case (op_q)
              OP_ADD: begin
                res_d   = {27'd0, a_q} + {27'd0, entry_bin};
                state_d = S_CHK;
              end
              OP_SUB: begin
                if (a_q < entry_bin) state_d = S_ERR;
                else begin
                  res_d   = {27'd0, a_q - entry_bin};
                  state_d = S_CHK;
                end
              end
              default: begin
                res_d    = '0;
                mcand_d  = {27'd0, a_q};
                mplier_d = entry_bin;
                iter_d   = '0;
                state_d  = S_MUL;
              end
            endcase
          end else if (cmd == 4'd14) begin
            do_clear = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) res_d = res_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + 5'd1;
        if (iter_q == 5'd26) state_d = S_CHK;
      end
      S_CHK: begin
        if (res_q > MAX_RES) state_d = S_ERR;
        else begin
          bin_d   = res_q[26:0];
          bcd_d   = '0;
          iter_d  = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d  = step[58:27];
        bin_d  = step[26:0];
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd26) begin
          entry_d    = step[58:27];
          cnt_d      = sig_cnt(step[58:27]);
          a_d        = '0;
          op_d       = OP_NONE;
          op_wait_d  = 1'b0;
          res_flag_d = 1'b1;
          state_d    = S_EDIT;
        end
      end
      S_ERR: begin
        if (accept && cmd == 4'd14) do_clear = 1'b1;
      end
      default: state_d = S_EDIT;
    endcase

    if (do_clear) begin
      entry_d    = '0;
      cnt_d      = '0;
      a_d        = '0;
      op_d       = OP_NONE;
      op_wait_d  = 1'b0;
      res_flag_d = 1'b0;
      state_d    = S_EDIT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EDIT;
      prev_cmd_q <= 4'd15;
      entry_q    <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      op_q       <= OP_NONE;
      op_wait_q  <= 1'b0;
      res_flag_q <= 1'b0;
      res_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_cmd_q <= prev_cmd_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      op_q       <= op_d;
      op_wait_q  <= op_wait_d;
      res_flag_q <= res_flag_d;
      res_q      <= res_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
    end
  end

  assign status = (state_q == S_EDIT) ? 2'b00 :
                  (state_q == S_ERR)  ? 2'b10 : 2'b01;

  // Entry stays untouched while busy, so the pre-equals value keeps showing.
  logic       lz;
  logic [3:0] dig;
  always_comb begin
    lz  = 1'b1;
    dig = '0;
    for (int i = 0; i < 8; i++) displays[i] = 7'h00;
    for (int i = 7; i >= 0; i--) begin
      dig = entry_q[i*4 +: 4];
      if (dig != 4'd0) lz = 1'b0;
      if (state_q == S_ERR)    displays[i] = (i == 0) ? 7'h79 : 7'h00;
      else if (lz && i != 0)   displays[i] = 7'h00;
      else                     displays[i] = seg(dig);
    end
  end

endmodule

// File: tb/tb_calc_top.sv
// Directed bench for calc_top: keypad sequences with hand-computed display/status.
module tb_calc_top;

  logic       clock;
  logic       reset;
  logic [3:0] cmd;
  logic [6:0] displays [7:0];
  logic [1:0] status;

  int checks = 0;
  int errors = 0;

  calc_top dut (
    .clock   (clock),
    .reset   (reset),
    .cmd     (cmd),
    .displays(displays),
    .status  (status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp);
    chk(tag, {6'd0, status}, {6'd0, exp});
  endtask

  task automatic chk_d(input string tag, input int idx, input logic [6:0] exp);
    chk(tag, {1'b0, displays[idx]}, {1'b0, exp});
  endtask

  task automatic press(input logic [3:0] k);
    cmd = k;
    repeat (2) @(negedge clock);
    cmd = 4'd15;
    repeat (2) @(negedge clock);
  endtask

  task automatic eq_start(input string tag);
    cmd = 4'd13;
    @(negedge clock);
    chk_st(tag, 2'b01);
    cmd = 4'd15;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (status == 2'b01 && n < 70) begin
      @(negedge clock);
      n++;
    end
    checks++;
    assert (n <= 64) else begin
      errors++;
      $error("FAIL %s busy_cycles=%0d limit=64", tag, n);
    end
  endtask

  initial begin
    reset = 1'b0;
    cmd   = 4'd15;
    repeat (3) @(negedge clock);
    chk_st("rst_hold_status", 2'b00);
    reset = 1'b1;
    @(negedge clock);
    chk_st("rst_status", 2'b00);
    chk_d("rst_d0", 0, 7'h3F);
    chk_d("rst_d1", 1, 7'h00);
    chk_d("rst_d7", 7, 7'h00);

    // Held keys, repeated 3 without release
    cmd = 4'd1; repeat (10) @(negedge clock);
    cmd = 4'd2; repeat (10) @(negedge clock);
    cmd = 4'd3; repeat (10) @(negedge clock);
    cmd = 4'd3; repeat (10) @(negedge clock);
    chk_d("hold_d0", 0, 7'h4F);
    chk_d("hold_d1", 1, 7'h5B);
    chk_d("hold_d2", 2, 7'h06);
    chk_d("hold_d3", 3, 7'h00);
    chk_d("hold_d7", 7, 7'h00);
    press(4'd14);
    chk_d("clr_d0", 0, 7'h3F);
    chk_d("clr_d2", 2, 7'h00);

    // 12 + 34 = 46
    press(4'd1); press(4'd2); press(4'd10); press(4'd3); press(4'd4);
    chk_d("add_b_d1", 1, 7'h4F);
    chk_d("add_b_d0", 0, 7'h66);
    eq_start("add_busy");
    chk_d("add_hold_d0", 0, 7'h66);
    wait_done("add_time");
    chk_st("add_status", 2'b00);
    chk_d("add_d1", 1, 7'h66);
    chk_d("add_d0", 0, 7'h7D);
    chk_d("add_d2", 2, 7'h00);
    press(4'd14);

    // 12 * 34 = 408
    press(4'd1); press(4'd2); press(4'd12); press(4'd3); press(4'd4);
    eq_start("mul_busy");
    repeat (10) @(negedge clock);
    chk_st("mul_busy_mid", 2'b01);
    chk_d("mul_hold_d1", 1, 7'h4F);
    wait_done("mul_time");
    chk_st("mul_status", 2'b00);
    chk_d("mul_d2", 2, 7'h66);
    chk_d("mul_d1", 1, 7'h3F);
    chk_d("mul_d0", 0, 7'h7F);
    chk_d("mul_d3", 3, 7'h00);
    press(4'd14);

    // 5 - 9 -> negative -> error
    press(4'd5); press(4'd11); press(4'd9);
    cmd = 4'd13;
    @(negedge clock);
    cmd = 4'd15;
    @(negedge clock);
    chk_st("neg_status", 2'b10);
    chk_d("neg_d0", 0, 7'h79);
    chk_d("neg_d1", 1, 7'h00);
    press(4'd7);
    chk_st("err_ignore_status", 2'b10);
    chk_d("err_ignore_d0", 0, 7'h79);
    press(4'd14);
    chk_st("err_clr_status", 2'b00);
    chk_d("err_clr_d0", 0, 7'h3F);

    // 99999999 (ninth 9 dropped) + 1 -> overflow
    repeat (9) press(4'd9);
    chk_d("nine_d7", 7, 7'h6F);
    chk_d("nine_d0", 0, 7'h6F);
    press(4'd10); press(4'd1);
    eq_start("ovf_busy");
    wait_done("ovf_time");
    chk_st("ovf_status", 2'b10);
    chk_d("ovf_d0", 0, 7'h79);
    chk_d("ovf_d7", 7, 7'h00);
    press(4'd14);

    // Operator replacement: 8 add sub 3 = 5, then a digit starts a new entry
    press(4'd8); press(4'd10); press(4'd11); press(4'd3);
    eq_start("rep_busy");
    wait_done("rep_time");
    chk_d("rep_d0", 0, 7'h6D);
    chk_d("rep_d1", 1, 7'h00);
    press(4'd2);
    chk_d("new_d0", 0, 7'h5B);
    chk_d("new_d1", 1, 7'h00);
    press(4'd13);
    chk_st("eq_noop_status", 2'b00);
    chk_d("eq_noop_d0", 0, 7'h5B);

    // Leading zeros stay blank
    press(4'd14); press(4'd0); press(4'd0); press(4'd5);
    chk_d("lz_d0", 0, 7'h6D);
    chk_d("lz_d1", 1, 7'h00);

    // Clear while busy is ignored: 1 * 2 = 2
    press(4'd14); press(4'd1); press(4'd12); press(4'd2);
    cmd = 4'd13;
    @(negedge clock);
    chk_st("bclr_busy", 2'b01);
    cmd = 4'd14;
    repeat (3) @(negedge clock);
    cmd = 4'd15;
    wait_done("bclr_time");
    chk_st("bclr_status", 2'b00);
    chk_d("bclr_d0", 0, 7'h5B);

    // Reset during a multiply aborts immediately
    press(4'd14); press(4'd9); press(4'd9); press(4'd12); press(4'd9); press(4'd9);
    chk_d("pre_rst_d1", 1, 7'h6F);
    eq_start("rmul_busy");
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    chk_st("rmul_status", 2'b00);
    chk_d("rmul_d0", 0, 7'h3F);
    chk_d("rmul_d1", 1, 7'h00);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_st("post_rst_status", 2'b00);
    chk_d("post_rst_d0", 0, 7'h3F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_top.md
CALC_TOP -- requirements
Module: calc_top

Interface
REQ-001 clock  input  1  Sole clock; all state updates on the rising edge.
REQ-002 reset  input  1  Asynchronous, active-low reset; asserting it immediately forces the reset state.
REQ-003 cmd  input  4  Keypad command: 0-9 digit, 10 add, 11 subtract, 12 multiply, 13 equals, 14 clear, 15 idle (no-op).
REQ-004 displays  output  8x7 (unpacked [7:0] of [6:0])  Seven-segment patterns; index 0 is the least-significant digit; active-high, bit0=a ... bit6=g.
REQ-005 status  output  2  00 EDIT (ready), 01 BUSY (computing), 10 ERROR; 11 is never driven.

Function
REQ-006 cmd SHALL be sampled every cycle into a previous-cmd register; a command SHALL be accepted only when the sampled cmd differs from the previous-cmd value and is not 15.
REQ-007 A held cmd SHALL execute once; to repeat the same key, cmd SHALL pass through a different value (e.g. 15) first.
REQ-008 The entry register SHALL hold up to 8 BCD digits plus a digit count.
REQ-009 Digit in EDIT SHALL shift into the entry's least-significant position if fewer than 8 significant digits are present; otherwise it SHALL be ignored.
REQ-010 A digit accepted directly after an equals result SHALL start a new entry (result discarded).
REQ-011 Operator (10-12) in EDIT SHALL latch the displayed value as operand A (binary, 27 bits), store the operator, clear the entry; a second operator before any digit SHALL only replace the stored operator.
REQ-012 Equals with an operator pending SHALL compute A op B (B = current entry, 0 if empty) and enter BUSY; equals with no operator pending SHALL have no effect.
REQ-013 Add and subtract SHALL take 1 cycle; multiply SHALL use a 27-iteration shift-add, one iteration per cycle.
REQ-014 The binary result SHALL be converted to 8 BCD digits by iterative double-dabble (27 cycles); total BUSY time SHALL be at most 64 cycles.
REQ-015 Results greater than 99_999_999 or less than 0 SHALL enter ERROR instead of displaying.
REQ-016 On successful completion: the result becomes the entry, the pending operator clears, and status returns to EDIT.
REQ-017 While BUSY, all commands including clear SHALL be ignored (previous-cmd still updates).
REQ-018 In ERROR, only clear (14) SHALL be accepted.
REQ-019 Clear in EDIT or ERROR SHALL zero the entry, A and the operator, and return to EDIT.
REQ-020 Display digits SHALL be 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex).
REQ-021 Leading zeros SHALL be blanked (00); displays[0] SHALL always show a digit.
REQ-022 In ERROR, displays[0] SHALL be 79 ('E') and displays[7:1] SHALL be 00.
REQ-023 During BUSY, displays SHALL hold the value shown before equals.
REQ-024 Outputs SHALL be registered or decoded from registered state only; no combinational path from cmd to any output.

Reset
REQ-025 Reset SHALL set:
- entry, A and the operator to 0;
- previous-cmd to 15;
- state to EDIT, status 00;
- displays[0] to 3F and displays[7:1] to 00.
REQ-026 Reset asserted mid-computation SHALL abort immediately to the reset state.

Verification
REQ-027 Assert reset, release -> status 00, displays[0]=3F, displays[7:1]=00.
REQ-028 cmd 1,2,3,3 each held 10 cycles -> displays[2:0]=06,5B,4F ("123"; the repeated 3 is not re-entered), displays[7:3]=00.
REQ-029 1,2,add,3,4,equals (15 between repeats) -> status 01 then 00 within 64 cycles; displays[1:0]=66,7D ("46").
REQ-030 1,2,multiply,3,4,equals -> status 01 during compute, then displays[2:0]=66,3F,7F ("408"), status 00.
REQ-031 5,subtract,9,equals -> status 10, displays[0]=79; then clear -> status 00, displays[0]=3F.
REQ-032 Enter 9 nine times (8 digits kept), add, 1, equals -> status 10; reset asserted during BUSY of a multiply -> reset state immediately.
